turn_signal_ctrl: RTL and testbench
===================================

Name: turn_signal_ctrl

Overview:
Turn-indicator controller that sits directly upstream of the sound unit. It converts raw lever and hazard-button inputs into blinking left/right lamp drives. It also produces the turn_signal_on blink-phase level, which the sound unit edge-detects to generate its tick/tock clicks. The block handles debouncing, hazard latching, direction priority and comfort (lane-change) blinking.

Parameters:
- BLINK_HALF_CYCLES, 16_666_667: clk cycles per ON or OFF half-phase (1.5 Hz at 50 MHz).
- DEBOUNCE_CYCLES, 500_000: cycles an input must be stable before acceptance (10 ms).
- COMFORT_BLINKS, 3: minimum completed ON phases after any lever activation.

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  reset, asynchronous, active-high
- sw_left  in  1  lever left, raw async level
- sw_right  in  1  lever right, raw async level
- sw_hazard  in  1  hazard push-button, raw async level
- engine_on  in  1  engine state, synchronous
- lamp_left  out  1  left indicator lamp drive
- lamp_right  out  1  right indicator lamp drive
- turn_signal_on  out  1  blink phase, = lamp_left | lamp_right; feeds the sound unit
- active_dir  out  2  0 none, 1 left, 2 right, 3 hazard

Behaviour:
- Reset (async):
  - All outputs 0, state IDLE, hazard latch 0.
  - Phase OFF, timer 0, on_count 0.
- Input conditioning (sw_left, sw_right, sw_hazard): 2-FF synchroniser, then a stable-count debounce. A new level is accepted after DEBOUNCE_CYCLES consecutive equal samples.
- Hazard latch: toggles on each rising edge of debounced sw_hazard. It ignores engine_on.
- Lever decode: lev_l = dL & ~dR; lev_r = dR & ~dL. Both asserted is treated as neutral.
- States: IDLE, LEFT, RIGHT, HAZARD. Priority is HAZARD > direction change > sustain.
  - Any state -> HAZARD when the latch is set. Restart on entry.
  - HAZARD -> LEFT/RIGHT if the latch clears and the lever is held with engine_on. Restart on entry.
  - HAZARD -> IDLE otherwise. No comfort blinks after hazard.
  - IDLE -> LEFT/RIGHT on lev_l/lev_r when engine_on=1. Restart on entry.
  - LEFT <-> RIGHT directly on opposite lever. Restart.
  - LEFT/RIGHT -> IDLE immediately when engine_on=0.
  - LEFT/RIGHT -> IDLE on lever neutral, but only when phase is OFF and on_count >= COMFORT_BLINKS. An ON phase is never truncated.
- Restart: phase=ON, timer=0, on_count=0.
- Timer:
  - Counts in any non-IDLE state. At BLINK_HALF_CYCLES-1 it wraps to 0 and phase toggles.
  - On each ON->OFF toggle, on_count increments, saturating at COMFORT_BLINKS.
- Lamps:
  - LEFT drives lamp_left = phase; RIGHT drives lamp_right = phase.
  - HAZARD drives both lamps = phase. IDLE drives both 0.
- Latency:
  - All outputs are registered.
  - Debounced-input change to lamp ON takes 1 FSM cycle plus 1 output register.
  - Raw input to lamp ON is 2 + DEBOUNCE_CYCLES + 2 cycles.
- Simultaneous events:
  - A hazard toggle in the same cycle as a lever change resolves to hazard.
  - engine_on falling in the same cycle as an ON->OFF toggle forces IDLE.
- Width rules:
  - Timer width is $clog2(BLINK_HALF_CYCLES).
  - on_count width is $clog2(COMFORT_BLINKS+1).

Optional Feature:
- Macro TURN_SIG_COMFORT_EN.
- Defined: comfort sustain as above (COMFORT_BLINKS minimum ON phases).
- Undefined:
  - On lever neutral, exit at the next ON->OFF boundary, or immediately if already OFF.
  - on_count logic is removed.
  - The COMFORT_BLINKS parameter is retained but unused.

Decomposition:
- Package turn_sig_pkg:
  - state enum (IDLE, LEFT, RIGHT, HAZARD)
  - active_dir encodings (DIR_NONE=0, DIR_LEFT=1, DIR_RIGHT=2, DIR_HAZARD=3)
- Sub-module switch_debounce (sync + stable counter, parameter DEBOUNCE_CYCLES), instantiated 3 times.

Test Plan (BLINK_HALF_CYCLES=10, DEBOUNCE_CYCLES=4, COMFORT_BLINKS=3):
- engine_on=1, sw_left held 100 cycles -> lamp_left toggles every 10 cycles starting ON; lamp_right=0; active_dir=1; turn_signal_on == lamp_left.
- sw_left pulsed for 8 cycles -> exactly 3 ON phases of 10 cycles each, then IDLE; active_dir=0.
- Blinking left, then switch to sw_right -> lamp_left drops and lamp_right goes ON within 2 cycles of debounced change; on_count resets; fresh 10-cycle ON phase.
- engine_on=0, sw_hazard press -> both lamps blink in phase, active_dir=3; second press with no lever -> IDLE on next cycle, no comfort blinks.
- Mid-ON-phase engine_on falls -> lamps 0 next cycle. Separately, rst asserted mid-blink -> all outputs 0 asynchronously and hazard latch cleared.
- sw_left and sw_right both held -> stays IDLE. Separately, a 3-cycle glitch on sw_right -> no response.

Source files
------------

// File: rtl/turn_sig_pkg.sv
// Shared types for the turn-indicator controller: FSM state encoding and
// active_dir output codes.
package turn_sig_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLeft   = 2'd1,
    StRight  = 2'd2,
    StHazard = 2'd3
  } state_e;

  localparam logic [1:0] DIR_NONE   = 2'd0;
  localparam logic [1:0] DIR_LEFT   = 2'd1;
  localparam logic [1:0] DIR_RIGHT  = 2'd2;
  localparam logic [1:0] DIR_HAZARD = 2'd3;

  function automatic logic [1:0] dir_of(state_e st);
    logic [1:0] dir;
    dir = DIR_NONE;
    unique case (st)
      StIdle:   dir = DIR_NONE;
      StLeft:   dir = DIR_LEFT;
      StRight:  dir = DIR_RIGHT;
      StHazard: dir = DIR_HAZARD;
      default:  dir = DIR_NONE;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer: a new level is
// accepted once DEBOUNCE_CYCLES consecutive synchronised samples differ from the output.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_db
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    // Any sample equal to the current output restarts the stability count.
    if (sync2_q != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_db = db_q;

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-indicator controller: debounced lever/hazard inputs drive a blinking FSM.
// Define TURN_SIG_COMFORT_EN to enable minimum-blink (lane-change) comfort sustain.
module turn_signal_ctrl #(
  parameter int unsigned BLINK_HALF_CYCLES = 16_666_667,
  parameter int unsigned DEBOUNCE_CYCLES   = 500_000,
  parameter int unsigned COMFORT_BLINKS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_hazard,
  input  logic       engine_on,
  output logic       lamp_left,
  output logic       lamp_right,
  output logic       turn_signal_on,
  output logic [1:0] active_dir
);

  import turn_sig_pkg::*;

  localparam int unsigned TimerW = $clog2(BLINK_HALF_CYCLES);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(BLINK_HALF_CYCLES - 1);

  logic db_left, db_right, db_hazard;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_left),
    .sw_db  (db_left)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_right),
    .sw_db  (db_right)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_hazard),
    .sw_db  (db_hazard)
  );

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                phase_q, phase_d;
  logic                haz_prev_q, haz_prev_d;
  logic                haz_latch_q, haz_latch_d;
  logic                lamp_left_q, lamp_left_d;
  logic                lamp_right_q, lamp_right_d;
  logic                turn_q, turn_d;
  logic [1:0]          dir_q, dir_d;
  logic                lev_l, lev_r, half_done, neutral_exit, restart;

`ifdef TURN_SIG_COMFORT_EN
  localparam int unsigned OnCntW = $clog2(COMFORT_BLINKS + 1);
  localparam logic [OnCntW-1:0] OnCntMax = OnCntW'(COMFORT_BLINKS);
  logic [OnCntW-1:0] on_cnt_q, on_cnt_d;
`endif

  assign lev_l      = db_left & ~db_right;
  assign lev_r      = db_right & ~db_left;
  assign half_done  = (timer_q == TimerMax);
  assign haz_prev_d = db_hazard;
  // Feeding the FSM the next latch value lets a same-cycle press win over a lever change.
  assign haz_latch_d = haz_latch_q ^ (db_hazard & ~haz_prev_q);

`ifdef TURN_SIG_COMFORT_EN
  assign neutral_exit = ~phase_q & (on_cnt_q >= OnCntMax);
`else
  assign neutral_exit = ~phase_q | half_done;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    phase_d = phase_q;
    restart = 1'b0;
`ifdef TURN_SIG_COMFORT_EN
    on_cnt_d = on_cnt_q;
`endif

    if (state_q != StIdle) begin
      if (half_done) begin
        timer_d = '0;
        phase_d = ~phase_q;
`ifdef TURN_SIG_COMFORT_EN
        if (phase_q && (on_cnt_q < OnCntMax)) on_cnt_d = on_cnt_q + 1'b1;
`endif
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (haz_latch_d) begin
      if (state_q != StHazard) begin
        state_d = StHazard;
        restart = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle, StHazard: begin
          if (engine_on && lev_l) begin
            state_d = StLeft;
            restart = 1'b1;
          end else if (engine_on && lev_r) begin
            state_d = StRight;
            restart = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
        StLeft: begin
          if (!engine_on) begin
            state_d = StIdle;
          end else if (lev_r) begin
            state_d = StRight;
            restart = 1'b1;
          end else if (!lev_l && neutral_exit) begin
            state_d = StIdle;
          end
        end
        StRight: begin
          if (!engine_on) begin
            state_d = StIdle;
          end else if (lev_l) begin
            state_d = StLeft;
            restart = 1'b1;
          end else if (!lev_r && neutral_exit) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (restart || (state_d == StIdle)) begin
      phase_d = restart;
      timer_d = '0;
`ifdef TURN_SIG_COMFORT_EN
      on_cnt_d = '0;
`endif
    end
  end

  always_comb begin
    lamp_left_d  = phase_q & ((state_q == StLeft) | (state_q == StHazard));
    lamp_right_d = phase_q & ((state_q == StRight) | (state_q == StHazard));
    turn_d       = lamp_left_d | lamp_right_d;
    dir_d        = dir_of(state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      phase_q      <= 1'b0;
      haz_prev_q   <= 1'b0;
      haz_latch_q  <= 1'b0;
      lamp_left_q  <= 1'b0;
      lamp_right_q <= 1'b0;
      turn_q       <= 1'b0;
      dir_q        <= DIR_NONE;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      phase_q      <= phase_d;
      haz_prev_q   <= haz_prev_d;
      haz_latch_q  <= haz_latch_d;
      lamp_left_q  <= lamp_left_d;
      lamp_right_q <= lamp_right_d;
      turn_q       <= turn_d;
      dir_q        <= dir_d;
    end
  end

`ifdef TURN_SIG_COMFORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) on_cnt_q <= '0;
    else     on_cnt_q <= on_cnt_d;
  end
`endif

  assign lamp_left      = lamp_left_q;
  assign lamp_right     = lamp_right_q;
  assign turn_signal_on = turn_q;
  assign active_dir     = dir_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed self-checking bench for turn_signal_ctrl with short blink/debounce timing.
// Expectations for the lever-release scenario follow TURN_SIG_COMFORT_EN.
module tb_turn_signal_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_left = 1'b0, sw_right = 1'b0, sw_hazard = 1'b0, engine_on = 1'b0;
  logic       lamp_left, lamp_right, turn_signal_on;
  logic [1:0] active_dir;

  int checks = 0;
  int failures = 0;

  turn_signal_ctrl #(
    .BLINK_HALF_CYCLES (10),
    .DEBOUNCE_CYCLES   (4),
    .COMFORT_BLINKS    (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_left        (sw_left),
    .sw_right       (sw_right),
    .sw_hazard      (sw_hazard),
    .engine_on      (engine_on),
    .lamp_left      (lamp_left),
    .lamp_right     (lamp_right),
    .turn_signal_on (turn_signal_on),
    .active_dir     (active_dir)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After return, the next rising edge is edge 1 of the scenario timeline.
  task automatic apply_reset(input logic eng);
    rst = 1'b1;
    sw_left = 1'b0;
    sw_right = 1'b0;
    sw_hazard = 1'b0;
    engine_on = eng;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    checks += 4;
    if (lamp_left !== 1'b0) begin failures++; $display("FAIL reset_lamp_left got=%b exp=0", lamp_left); end
    if (lamp_right !== 1'b0) begin failures++; $display("FAIL reset_lamp_right got=%b exp=0", lamp_right); end
    if (turn_signal_on !== 1'b0) begin failures++; $display("FAIL reset_turn got=%b exp=0", turn_signal_on); end
    if (active_dir !== 2'd0) begin failures++; $display("FAIL reset_dir got=%0d exp=0", active_dir); end
  endtask

  task automatic test_hold_left();
    logic exp_l;
    logic [1:0] exp_dir;
    apply_reset(1'b1);
    sw_left = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      exp_l = (k >= 8) && (((k - 8) / 10) % 2 == 0);
      exp_dir = (k >= 8) ? 2'd1 : 2'd0;
      checks += 4;
      if (lamp_left !== exp_l) begin failures++; $display("FAIL hold_left_lamp k=%0d got=%b exp=%b", k, lamp_left, exp_l); end
      if (lamp_right !== 1'b0) begin failures++; $display("FAIL hold_left_right k=%0d got=%b exp=0", k, lamp_right); end
      if (turn_signal_on !== exp_l) begin failures++; $display("FAIL hold_left_turn k=%0d got=%b exp=%b", k, turn_signal_on, exp_l); end
      if (active_dir !== exp_dir) begin failures++; $display("FAIL hold_left_dir k=%0d got=%0d exp=%0d", k, active_dir, exp_dir); end
    end
    sw_left = 1'b0;
  endtask

  task automatic test_comfort_pulse();
    logic exp_l;
    logic [1:0] exp_dir;
    apply_reset(1'b1);
    sw_left = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
`ifdef TURN_SIG_COMFORT_EN
      exp_l = (k >= 8 && k <= 17) || (k >= 28 && k <= 37) || (k >= 48 && k <= 57);
      exp_dir = (k >= 8 && k <= 58) ? 2'd1 : 2'd0;
`else
      exp_l = (k >= 8 && k <= 17);
      exp_dir = (k >= 8 && k <= 17) ? 2'd1 : 2'd0;
`endif
      checks += 3;
      if (lamp_left !== exp_l) begin failures++; $display("FAIL pulse_lamp k=%0d got=%b exp=%b", k, lamp_left, exp_l); end
      if (turn_signal_on !== exp_l) begin failures++; $display("FAIL pulse_turn k=%0d got=%b exp=%b", k, turn_signal_on, exp_l); end
      if (active_dir !== exp_dir) begin failures++; $display("FAIL pulse_dir k=%0d got=%0d exp=%0d", k, active_dir, exp_dir); end
      if (k == 8) sw_left = 1'b0;
    end
  endtask

  task automatic test_dir_change();
    logic exp_l, exp_r;
    logic [1:0] exp_dir;
    apply_reset(1'b1);
    sw_left = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      exp_l = (k >= 8 && k <= 17) || (k >= 28 && k <= 32);
      exp_r = (k >= 33 && k <= 42);
      exp_dir = (k < 8) ? 2'd0 : (k <= 32) ? 2'd1 : 2'd2;
      checks += 3;
      if (lamp_left !== exp_l) begin failures++; $display("FAIL change_left k=%0d got=%b exp=%b", k, lamp_left, exp_l); end
      if (lamp_right !== exp_r) begin failures++; $display("FAIL change_right k=%0d got=%b exp=%b", k, lamp_right, exp_r); end
      if (active_dir !== exp_dir) begin failures++; $display("FAIL change_dir k=%0d got=%0d exp=%0d", k, active_dir, exp_dir); end
      if (k == 25) begin
        sw_left = 1'b0;
        sw_right = 1'b1;
      end
    end
    sw_right = 1'b0;
  endtask

  task automatic test_hazard();
    logic exp_l;
    logic [1:0] exp_dir;
    apply_reset(1'b0);
    sw_hazard = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      exp_l = (k >= 8 && k <= 17) || (k >= 28 && k <= 37);
      exp_dir = (k >= 8 && k <= 47) ? 2'd3 : 2'd0;
      checks += 4;
      if (lamp_left !== exp_l) begin failures++; $display("FAIL hazard_left k=%0d got=%b exp=%b", k, lamp_left, exp_l); end
      if (lamp_right !== exp_l) begin failures++; $display("FAIL hazard_right k=%0d got=%b exp=%b", k, lamp_right, exp_l); end
      if (turn_signal_on !== exp_l) begin failures++; $display("FAIL hazard_turn k=%0d got=%b exp=%b", k, turn_signal_on, exp_l); end
      if (active_dir !== exp_dir) begin failures++; $display("FAIL hazard_dir k=%0d got=%0d exp=%0d", k, active_dir, exp_dir); end
      if (k == 8 || k == 48) sw_hazard = 1'b0;
      if (k == 40) sw_hazard = 1'b1;
    end
  endtask

  task automatic test_engine_off();
    logic exp_l;
    logic [1:0] exp_dir;
    apply_reset(1'b1);
    sw_left = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_l = (k >= 8 && k <= 11);
      exp_dir = (k >= 8 && k <= 11) ? 2'd1 : 2'd0;
      checks += 2;
      if (lamp_left !== exp_l) begin failures++; $display("FAIL engine_off_lamp k=%0d got=%b exp=%b", k, lamp_left, exp_l); end
      if (active_dir !== exp_dir) begin failures++; $display("FAIL engine_off_dir k=%0d got=%0d exp=%0d", k, active_dir, exp_dir); end
      if (k == 10) engine_on = 1'b0;
    end
    sw_left = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset(1'b1);
    sw_hazard = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 8) sw_hazard = 1'b0;
    end
    checks += 1;
    if (lamp_left !== 1'b1) begin failures++; $display("FAIL areset_pre_lamp got=%b exp=1", lamp_left); end
    #3;
    rst = 1'b1;
    #1;
    checks += 4;
    if (lamp_left !== 1'b0) begin failures++; $display("FAIL areset_left got=%b exp=0", lamp_left); end
    if (lamp_right !== 1'b0) begin failures++; $display("FAIL areset_right got=%b exp=0", lamp_right); end
    if (turn_signal_on !== 1'b0) begin failures++; $display("FAIL areset_turn got=%b exp=0", turn_signal_on); end
    if (active_dir !== 2'd0) begin failures++; $display("FAIL areset_dir got=%0d exp=0", active_dir); end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks += 2;
      if (active_dir !== 2'd0) begin failures++; $display("FAIL areset_latch_dir k=%0d got=%0d exp=0", k, active_dir); end
      if (lamp_left !== 1'b0) begin failures++; $display("FAIL areset_latch_lamp k=%0d got=%b exp=0", k, lamp_left); end
    end
  endtask

  task automatic test_both_levers();
    apply_reset(1'b1);
    sw_left = 1'b1;
    sw_right = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks += 2;
      if (active_dir !== 2'd0) begin failures++; $display("FAIL both_dir k=%0d got=%0d exp=0", k, active_dir); end
      if (turn_signal_on !== 1'b0) begin failures++; $display("FAIL both_turn k=%0d got=%b exp=0", k, turn_signal_on); end
    end
    sw_left = 1'b0;
    sw_right = 1'b0;
  endtask

  task automatic test_glitch();
    apply_reset(1'b1);
    sw_right = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks += 2;
      if (active_dir !== 2'd0) begin failures++; $display("FAIL glitch_dir k=%0d got=%0d exp=0", k, active_dir); end
      if (lamp_right !== 1'b0) begin failures++; $display("FAIL glitch_lamp k=%0d got=%b exp=0", k, lamp_right); end
      if (k == 3) sw_right = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_hold_left();
    test_comfort_pulse();
    test_dir_change();
    test_hazard();
    test_engine_off();
    test_async_reset();
    test_both_levers();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
